// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: load/store width codes and responder FSM state type
package dmem_responder_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
endpackage

// File: rtl/dmem_responder_mem_lane_align.sv
// mem_lane_align: byte enables/write lanes for stores, load extraction/extension, misalign and illegal func3 flags (in: is_load, lo, func3, wdata, rword; out: be, wdata_sh, rdata_ext, misalign, bad_f3)
module mem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        is_load,
  input  logic [1:0]  lo,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        bad_f3
);
  logic [31:0] rsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    rsh       = rword >> {lo, 3'b000};
    byte_v    = rsh[7:0];
    half_v    = lo[1] ? rword[31:16] : rword[15:0];
    be        = func3 == F3_B ? 4'b0001 << lo :
                func3 == F3_H ? 4'b0011 << {lo[1], 1'b0} :
                func3 == F3_W ? 4'hf : 4'h0;
    wdata_sh  = func3 == F3_B ? {4{wdata[7:0]}} :
                func3 == F3_H ? {2{wdata[15:0]}} : wdata;
    rdata_ext = func3 == F3_B  ? {{24{byte_v[7]}}, byte_v} :
                func3 == F3_BU ? {24'd0, byte_v} :
                func3 == F3_H  ? {{16{half_v[15]}}, half_v} :
                func3 == F3_HU ? {16'd0, half_v} : rword;
    bad_f3    = is_load ? !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                        : !(func3 inside {F3_B, F3_H, F3_W});
    misalign  = (func3[1:0] == 2'b01 && lo[0]) || (func3 == F3_W && lo != 2'b00);
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle MEM-stage data memory with wait states (in: clk, rst_n, mem_read, mem_write, addr, wdata, func3; out: stall, done, rdata, err)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  dmem_state_t state, state_nx;
  logic [3:0]  cnt;
  logic        op_rd, op_wr, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [3:0]  be;
  logic [31:0] wdata_sh, rdata_ext, rword;
  logic        misalign, bad_f3, oob, req_err, fire, req;
  assign req     = mem_read || mem_write;
  assign rword   = mem[addr_q[IW+1:2]];
  assign oob     = (addr_q[31:2] >> IW) != '0;
  assign req_err = (op_rd && op_wr) || bad_f3 || misalign || oob;
  assign fire    = state == BUSY && cnt == 4'd0;
  mem_lane_align u_align (
    .is_load  (op_rd),
    .lo       (addr_q[1:0]),
    .func3    (f3_q),
    .wdata    (wdata_q),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext),
    .misalign (misalign),
    .bad_f3   (bad_f3)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (req ? BUSY : IDLE) :
               state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
  always_comb begin
    stall = (state == IDLE && req) || state == BUSY;
    done  = state == DONE;
    rdata = done ? rdata_q : 32'd0;
    err   = done && err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= 4'd0;
      op_rd   <= 1'b0;
      op_wr   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        op_rd   <= mem_read;
        op_wr   <= mem_write;
        addr_q  <= addr;
        wdata_q <= wdata;
        f3_q    <= func3;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (fire) begin
        rdata_q <= (req_err || !op_rd) ? 32'd0 : rdata_ext;
        err_q   <= req_err;
      end
    end
  always_ff @(posedge clk)
    if (fire && op_wr && !req_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[IW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (WAIT_STATES 1, plus 0 and 15 latency sweep)
module tb_dmem_responder;
  import dmem_responder_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [2:0]  func3 = 3'd0;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        s_rd = 1'b0, s_wr = 1'b0;
  logic [31:0] s_addr = 32'd0, s_wdata = 32'd0;
  logic [2:0]  s_f3 = 3'd0;
  logic        stall0, done0, err0, stall15, done15, err15;
  logic [31:0] rdata0, rdata15;
  int          checks = 0, errors = 0;
  logic [32:0] sb_q[$];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .wdata(wdata), .func3(func3), .stall(stall), .done(done), .rdata(rdata), .err(err));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) d0 (
    .clk(clk), .rst_n(rst_n), .mem_read(s_rd), .mem_write(s_wr), .addr(s_addr),
    .wdata(s_wdata), .func3(s_f3), .stall(stall0), .done(done0), .rdata(rdata0), .err(err0));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(15)) d15 (
    .clk(clk), .rst_n(rst_n), .mem_read(s_rd), .mem_write(s_wr), .addr(s_addr),
    .wdata(s_wdata), .func3(s_f3), .stall(stall15), .done(done15), .rdata(rdata15), .err(err15));
  task automatic access(input string name, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] er,
                        input logic ee, input logic hold);
    int lat;
    logic [32:0] exp;
    sb_q.push_back({ee, er});
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; func3 = f3;
    #1;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL %s stall cycle %0d: got %b want 1", name, lat, stall);
      end
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d want 3", name, lat);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL %s stall in done: got %b want 0", name, stall);
    end
    exp = sb_q.size() != 0 ? sb_q.pop_front() : 33'h0;
    checks++;
    if (rdata !== exp[31:0]) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", name, rdata, exp[31:0]);
    end
    checks++;
    if (err !== exp[32]) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, err, exp[32]);
    end
    if (!hold) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, done, err, rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b/%b/%b/%h want 0/0/0/0", stall, done, err, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({stall, done, err, rdata} !== 35'd0) begin
      errors++;
      $display("FAIL post-reset idle: got %b/%b/%b/%h want 0/0/0/0", stall, done, err, rdata);
    end
  endtask
  task automatic test_loads();
    access("sw_10", 0, 1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 0, 0);
    access("lb_13", 1, 0, 32'h13, 32'h0, F3_B, 32'hFFFFFFDE, 0, 0);
    access("lbu_13", 1, 0, 32'h13, 32'h0, F3_BU, 32'h000000DE, 0, 0);
    access("lh_12", 1, 0, 32'h12, 32'h0, F3_H, 32'hFFFFDEAD, 0, 0);
    access("lhu_10", 1, 0, 32'h10, 32'h0, F3_HU, 32'h0000BEEF, 0, 0);
    access("sb_11", 0, 1, 32'h11, 32'h55, F3_B, 32'h0, 0, 0);
    access("lw_10", 1, 0, 32'h10, 32'h0, F3_W, 32'hDEAD55EF, 0, 0);
  endtask
  task automatic test_back_to_back();
    access("b2b_sw", 0, 1, 32'h20, 32'h11111111, F3_W, 32'h0, 0, 1);
    access("b2b_lw", 1, 0, 32'h20, 32'h0, F3_W, 32'h11111111, 0, 1);
    access("b2b_sh", 0, 1, 32'h22, 32'h0000ABCD, F3_H, 32'h0, 0, 1);
    access("b2b_lw2", 1, 0, 32'h20, 32'h0, F3_W, 32'hABCD1111, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: got stall=%b done=%b want 0/0", stall, done);
    end
  endtask
  task automatic test_errors();
    access("lw_mis", 1, 0, 32'h12, 32'h0, F3_W, 32'h0, 1, 0);
    access("sh_mis", 0, 1, 32'h11, 32'h1234, F3_H, 32'h0, 1, 0);
    access("st_badf3", 0, 1, 32'h10, 32'h0, 3'b100, 32'h0, 1, 0);
    access("ld_badf3", 1, 0, 32'h10, 32'h0, 3'b011, 32'h0, 1, 0);
    access("rw_both", 1, 1, 32'h10, 32'h0, F3_W, 32'h0, 1, 0);
    access("lw_keep", 1, 0, 32'h10, 32'h0, F3_W, 32'hDEAD55EF, 0, 0);
    access("lw_oob", 1, 0, 32'h1000, 32'h0, F3_W, 32'h0, 1, 0);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h22222222; func3 = F3_W;
    @(negedge clk);
    rst_n = 1'b0;
    mem_write = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid-reset: got stall=%b done=%b want 0/0", stall, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after mid-reset: got stall=%b done=%b want 0/0", stall, done);
    end
    access("lw_old", 1, 0, 32'h20, 32'h0, F3_W, 32'hABCD1111, 0, 0);
  endtask
  task automatic test_wait_sweep();
    int n, t0, t15;
    @(negedge clk);
    s_wr = 1'b1; s_addr = 32'h0; s_wdata = 32'h12345678; s_f3 = F3_W;
    #1;
    n = 0; t0 = -1; t15 = -1;
    while ((t0 < 0 || t15 < 0) && n < 40) begin
      if (done0 === 1'b1 && t0 < 0) t0 = n;
      if (done15 === 1'b1 && t15 < 0) t15 = n;
      @(negedge clk);
      s_wr = 1'b0;
      #1;
      n++;
    end
    checks++;
    if (t0 !== 2) begin
      errors++;
      $display("FAIL ws0 done cycle: got %0d want 2", t0);
    end
    checks++;
    if (t15 !== 17) begin
      errors++;
      $display("FAIL ws15 done cycle: got %0d want 17", t15);
    end
  endtask
  initial begin
    test_reset();
    test_loads();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_wait_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
